// File: rtl/sys_ctrl_pkg.sv
// Shared types and defaults for the UART command sequencer (sys_ctrl_cmd).
package sys_ctrl_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam logic [7:0]  DEF_WR_CMD     = 8'hAA;
  localparam logic [7:0]  DEF_RD_CMD     = 8'hBB;

  typedef enum logic [2:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdWait,
    StTxSend
  } state_e;

endpackage

// File: rtl/sys_ctrl_frame_timer.sv
// Inter-byte idle counter for frames in flight; flags expiry after TIMEOUT_CYCLES-1 idle cycles.
module sys_ctrl_frame_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic active,
  input  logic rx_vld,
  output logic expire
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] count_q, count_d;

  // Every state change inside a frame is caused by a byte or by expiry, so clearing on
  // rx_vld and while inactive also covers the clear-on-state-change case.
  always_comb begin
    count_d = count_q + 1'b1;
    if (!active || rx_vld) begin
      count_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = active && !rx_vld && (count_q == CntW'(TIMEOUT_CYCLES - 2));

endmodule

// File: rtl/sys_ctrl_cmd.sv
// Command decoder/sequencer between UART RX/TX and the register file.
// Optional inter-byte timeout enabled with `define SYS_CTRL_TIMEOUT_EN.
module sys_ctrl_cmd
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned           ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] WR_CMD         = DATA_WIDTH'(DEF_WR_CMD),
  parameter logic [DATA_WIDTH-1:0] RD_CMD         = DATA_WIDTH'(DEF_RD_CMD),
  parameter int unsigned           TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  Rd_VLD,
  input  logic                  TX_BUSY,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CMD_ERR
);

  if (TIMEOUT_CYCLES < 2 || ADDR_WIDTH > DATA_WIDTH) begin : g_bad_params
    $error("sys_ctrl_cmd: TIMEOUT_CYCLES must be >= 2 and ADDR_WIDTH <= DATA_WIDTH");
  end

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  cmd_err_q, cmd_err_d;

`ifdef SYS_CTRL_TIMEOUT_EN
  logic frame_active;
  logic frame_expire;

  assign frame_active = (state_q == StWrAddr) || (state_q == StWrData) ||
                        (state_q == StRdAddr);

  sys_ctrl_frame_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_timer (
    .CLK    (CLK),
    .RST    (RST),
    .active (frame_active),
    .rx_vld (RX_D_VLD),
    .expire (frame_expire)
  );
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    address_d = address_q;
    wr_data_d = wr_data_q;
    tx_buf_d  = tx_buf_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    tx_vld_d  = 1'b0;
    cmd_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD) begin
            state_d = StWrAddr;
          end else if (RX_P_DATA == RD_CMD) begin
            state_d = StRdAddr;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      StWrAddr: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = StWrData;
        end
      end
      StWrData: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = addr_q;
          wr_data_d = RX_P_DATA;
          state_d   = StIdle;
        end
      end
      StRdAddr: begin
        if (RX_D_VLD) begin
          rd_en_d   = 1'b1;
          addr_d    = RX_P_DATA[ADDR_WIDTH-1:0];
          address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = StRdWait;
        end
      end
      StRdWait: begin
        // Bytes arriving while a read is outstanding are dropped, not queued.
        cmd_err_d = RX_D_VLD;
        if (Rd_VLD) begin
          tx_buf_d = RdData;
          state_d  = StTxSend;
        end
      end
      StTxSend: begin
        cmd_err_d = RX_D_VLD;
        if (!TX_BUSY) begin
          tx_vld_d = 1'b1;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef SYS_CTRL_TIMEOUT_EN
    // Expiry only fires in cycles without a byte, so no strobe can coincide with it.
    if (frame_expire) begin
      state_d   = StIdle;
      cmd_err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      address_q <= '0;
      wr_data_q <= '0;
      tx_buf_q  <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_vld_q  <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      address_q <= address_d;
      wr_data_q <= wr_data_d;
      tx_buf_q  <= tx_buf_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      tx_vld_q  <= tx_vld_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = address_q;
  assign WrData    = wr_data_q;
  assign TX_P_DATA = tx_buf_q;
  assign TX_D_VLD  = tx_vld_q;
  assign CMD_ERR   = cmd_err_q;

endmodule
